// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if
//   Bundles the requester-side and SPI-master-side signals of spi_master_arbiter.
//   Per-requester fields are packed [1:0][...] arrays; index 0 is requester 0.
//   modport slave  : the arbiter itself
//   modport master : the environment (requesters + SPI byte-master)
// Signals
//   req/req_len/req_div/wdata      requester -> arbiter
//   wdata_ack/rdata/rvalid/gnt/done/err  arbiter -> requester
//   m_rd_en/m_sclk_div/m_tx_data   arbiter -> SPI master
//   m_rd_done/m_rd_data            SPI master -> arbiter
interface spi_master_arbiter_if #(
  parameter int LEN_W = 4
);
  logic [1:0]            req;
  logic [1:0][LEN_W-1:0] req_len;
  logic [1:0][7:0]       req_div;
  logic [1:0][7:0]       wdata;
  logic [1:0]            wdata_ack;
  logic [7:0]            rdata;
  logic [1:0]            rvalid;
  logic [1:0]            gnt;
  logic [1:0]            done;
  logic                  err;
  logic                  m_rd_en;
  logic [7:0]            m_sclk_div;
  logic [7:0]            m_tx_data;
  logic                  m_rd_done;
  logic [7:0]            m_rd_data;

  modport slave (
    input  req, req_len, req_div, wdata, m_rd_done, m_rd_data,
    output wdata_ack, rdata, rvalid, gnt, done, err, m_rd_en, m_sclk_div, m_tx_data
  );

  modport master (
    output req, req_len, req_div, wdata, m_rd_done, m_rd_data,
    input  wdata_ack, rdata, rvalid, gnt, done, err, m_rd_en, m_sclk_div, m_tx_data
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
//   Shares one SPI byte-master between two requesters. Round-robin grants whole
//   bursts, sequences each byte (LOAD -> XFER -> GAP) and returns every received
//   byte to the grantee. The SPI master keeps ownership of the SPI pins.
// Optional feature: define SPI_ARB_TIMEOUT_EN to enable a per-byte watchdog
//   (TIMEOUT cycles in XFER without m_rd_done aborts the burst and pulses err).
// Ports
//   clk, rst_n : clock (posedge) and asynchronous active-low reset
//   bus        : spi_master_arbiter_if.slave (requester and SPI-master sides)
module spi_master_arbiter #(
  parameter int LEN_W   = 4,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_master_arbiter_if.slave   bus
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  if (GAP_CYC < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("spi_master_arbiter: GAP_CYC and TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, XFER, GAP, DONE} state_t;

  state_t           state;
  logic             win;      // current grantee
  logic             last;     // most recent grantee, loses a tie
  logic [LEN_W-1:0] cnt;
  logic [GW-1:0]    gap_cnt;
  logic             pick;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo;
`else
  assign bus.err = 1'b0;
`endif

  // Single requester wins outright; on a tie the one not served last wins.
  assign pick = (&bus.req) ? ~last : bus.req[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      win            <= 1'b0;
      last           <= 1'b1;
      cnt            <= '0;
      gap_cnt        <= '0;
      bus.gnt        <= '0;
      bus.done       <= '0;
      bus.rvalid     <= '0;
      bus.wdata_ack  <= '0;
      bus.m_rd_en    <= 1'b0;
      bus.rdata      <= '0;
      bus.m_tx_data  <= '0;
      bus.m_sclk_div <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      bus.err        <= 1'b0;
      tmo            <= '0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      bus.done      <= '0;
      bus.rvalid    <= '0;
      bus.wdata_ack <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      bus.err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|bus.req) begin
            win     <= pick;
            bus.gnt <= {pick, ~pick};
            state   <= GRANT;
          end
        end
        GRANT: begin
          // Length and divider are frozen here for the whole burst.
          cnt            <= bus.req_len[win];
          bus.m_sclk_div <= bus.req_div[win];
          state          <= (bus.req_len[win] == '0) ? DONE : LOAD;
        end
        LOAD: begin
          bus.m_tx_data <= bus.wdata[win];
          bus.wdata_ack <= {win, ~win};
          bus.m_rd_en   <= 1'b1;
          gap_cnt       <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
          tmo           <= '0;
`endif
          state         <= XFER;
        end
        XFER: begin
          if (bus.m_rd_done) begin
            bus.rdata   <= bus.m_rd_data;
            bus.rvalid  <= {win, ~win};
            bus.m_rd_en <= 1'b0;
            if (cnt != '0) cnt <= cnt - 1'b1;
            state       <= GAP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (tmo == TW'(TIMEOUT - 1)) begin
            // Stuck master: abandon the rest of the burst but still close it.
            bus.m_rd_en <= 1'b0;
            bus.err     <= 1'b1;
            cnt         <= '0;
            state       <= DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
`endif
        end
        GAP: begin
          // Keeps m_rd_en low long enough for the master to re-arm.
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            state <= (cnt != '0) ? LOAD : DONE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: begin
          bus.done <= {win, ~win};
          bus.gnt  <= '0;
          last     <= win;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
